fan_link_tx: RTL and testbench

Host-side transmitter for the fan controller's parallel load interface. It accepts setpoint and ADC-sample update requests over two valid/ready channels and arbitrates between them round-robin. Each accepted request is driven onto the 8-bit data bus with a config select (1 = setpoint, 0 = ADC sample) and a level data-valid strobe. Data and config are held stable around the strobe, so the synchronously sampling receiver never latches a transitional value. It sits in the test/host harness (or a companion controller) that feeds the fan controller's data, strobe and config pins.

---
 rtl/fan_link_tx.sv | 69 ++++++
 tb/tb_fan_link_tx.sv | 121 ++++++++++++
 2 files changed

// File: rtl/fan_link_tx.sv
// fan_link_tx: round-robin setpoint/ADC request arbiter driving a strobed parallel load bus.
// Ports: clk_i/rstn_i (async active-low reset), enable_i gates new frames;
// set_*/adc_* are valid/ready request channels; data_o/config_o carry the
// frame (config 1 = setpoint), strobe_o is the data-valid strobe, busy_o is
// high while a frame runs, frame_done_o pulses once as a frame completes.
module fan_link_tx #(
  parameter int DATA_BITWIDTH = 8,
  parameter int SETUP_CYCLES = 2,
  parameter int STROBE_CYCLES = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     enable_i,
  input  logic [DATA_BITWIDTH-1:0] set_value_i,
  input  logic                     set_valid_i,
  output logic                     set_ready_o,
  input  logic [DATA_BITWIDTH-1:0] adc_value_i,
  input  logic                     adc_valid_i,
  output logic                     adc_ready_o,
  output logic [DATA_BITWIDTH-1:0] data_o,
  output logic                     config_o,
  output logic                     strobe_o,
  output logic                     busy_o,
  output logic                     frame_done_o
);
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
  state_t state, next_state;
  logic [3:0] phase;
  logic phase_end, last_set, set_xfer, adc_xfer;
  assign set_xfer = set_valid_i && set_ready_o;
  assign adc_xfer = adc_valid_i && adc_ready_o;
  assign phase_end = state == SETUP  ? phase == 4'(SETUP_CYCLES - 1) :
                     state == STROBE ? phase == 4'(STROBE_CYCLES - 1) :
                                       phase == 4'(HOLD_CYCLES - 1);
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) state <= IDLE;
    else state <= next_state;
  always_comb
    next_state = state == IDLE   ? ((set_xfer || adc_xfer) ? SETUP : IDLE) :
                 !phase_end      ? state :
                 state == SETUP  ? STROBE :
                 state == STROBE ? HOLD : IDLE;
  // Readys are gated by rstn_i so nothing is offered while reset is held.
  always_comb begin
    set_ready_o = rstn_i && state == IDLE && enable_i && (!adc_valid_i || !last_set);
    adc_ready_o = rstn_i && state == IDLE && enable_i && (!set_valid_i || last_set);
    busy_o = state != IDLE;
  end
  // Strobe and done are registered from next_state so they align with the state.
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      phase <= '0;
      data_o <= '0;
      config_o <= 1'b0;
      last_set <= 1'b0;
      strobe_o <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      phase <= (next_state != state || state == IDLE) ? 4'd0 : phase + 4'd1;
      if (set_xfer || adc_xfer) begin
        data_o <= set_xfer ? set_value_i : adc_value_i;
        config_o <= set_xfer;
        last_set <= set_xfer;
      end
      strobe_o <= next_state == STROBE;
      frame_done_o <= state == HOLD && next_state == IDLE;
    end
endmodule

// File: tb/tb_fan_link_tx.sv
// tb_fan_link_tx: directed self-checking bench for fan_link_tx (default and minimum timing).
module tb_fan_link_tx;
  logic clk = 1'b0;
  logic rstn, en, sval, aval, sr, ar, cfg, stb, busy, done;
  logic [7:0] sv, av, data;
  logic f_rstn, f_en, f_sval, f_aval, f_sr, f_ar, f_cfg, f_stb, f_busy, f_done;
  logic [7:0] f_sv, f_av, f_data;
  int checks = 0;
  int fails = 0;
  always #5 clk = ~clk;
  fan_link_tx dut (
    .clk_i(clk), .rstn_i(rstn), .enable_i(en),
    .set_value_i(sv), .set_valid_i(sval), .set_ready_o(sr),
    .adc_value_i(av), .adc_valid_i(aval), .adc_ready_o(ar),
    .data_o(data), .config_o(cfg), .strobe_o(stb), .busy_o(busy), .frame_done_o(done)
  );
  fan_link_tx #(.SETUP_CYCLES(1), .STROBE_CYCLES(1), .HOLD_CYCLES(1)) fast (
    .clk_i(clk), .rstn_i(f_rstn), .enable_i(f_en),
    .set_value_i(f_sv), .set_valid_i(f_sval), .set_ready_o(f_sr),
    .adc_value_i(f_av), .adc_valid_i(f_aval), .adc_ready_o(f_ar),
    .data_o(f_data), .config_o(f_cfg), .strobe_o(f_stb), .busy_o(f_busy), .frame_done_o(f_done)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask
  initial begin
    rstn = 0; en = 1; sval = 1; sv = 8'h80; aval = 1; av = 8'h33;
    f_rstn = 0; f_en = 0; f_sval = 0; f_sv = 8'h00; f_aval = 0; f_av = 8'h00;
    tick(2);
    chk("rst_data", data, 8'h00);
    chk("rst_cfg", cfg, 0);
    chk("rst_strobe", stb, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_set_ready", sr, 0);
    chk("rst_adc_ready", ar, 0);
    // Single ADC frame 0x5A, accepted in this cycle (T)
    rstn = 1; sval = 0; av = 8'h5A; #1;
    chk("t0_adc_ready", ar, 1);
    chk("t0_set_ready", sr, 1);
    tick(1); aval = 0;
    chk("t1_data", data, 8'h5A);
    chk("t1_cfg", cfg, 0);
    chk("t1_busy", busy, 1);
    chk("t1_strobe", stb, 0);
    tick(1); chk("t2_strobe", stb, 0);
    tick(1); chk("t3_strobe", stb, 1);
    tick(3); chk("t6_strobe", stb, 1);
    tick(1); chk("t7_strobe", stb, 0); chk("t7_busy", busy, 1);
    tick(1); chk("t8_busy", busy, 1); chk("t8_done", done, 0);
    tick(1); chk("t9_done", done, 1); chk("t9_busy", busy, 0);
    tick(1); chk("t10_done", done, 0);
    tick(2); chk("t12_data", data, 8'h5A);
    // Tie: SET then ADC then SET (last grant is ADC from previous frame)
    sval = 1; sv = 8'h80; aval = 1; av = 8'h33; #1;
    chk("tie0_set_ready", sr, 1);
    chk("tie0_adc_ready", ar, 0);
    tick(1); chk("tie1_data", data, 8'h80); chk("tie1_cfg", cfg, 1);
    tick(8); chk("tie9_adc_ready", ar, 1); chk("tie9_set_ready", sr, 0);
    tick(1); chk("tie10_data", data, 8'h33); chk("tie10_cfg", cfg, 0);
    tick(8); chk("tie18_set_ready", sr, 1);
    tick(1); chk("tie19_data", data, 8'h80); chk("tie19_cfg", cfg, 1);
    sval = 0; aval = 0;
    tick(8); chk("tie27_busy", busy, 0);
    // Enable low: no ready, no strobe
    en = 0; sval = 1; sv = 8'h11; #1;
    chk("en0_set_ready", sr, 0);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("en0_strobe", stb, 0);
      chk("en0_busy", busy, 0);
    end
    // Enable drop mid-strobe: frame completes, no new accept
    en = 1; #1;
    chk("en_t0_set_ready", sr, 1);
    tick(1); chk("en_t1_data", data, 8'h11);
    tick(3); en = 0; #1; chk("en_t4_strobe", stb, 1);
    tick(2); chk("en_t6_strobe", stb, 1);
    tick(1); chk("en_t7_strobe", stb, 0);
    tick(2); chk("en_t9_done", done, 1); chk("en_t9_set_ready", sr, 0);
    tick(1); chk("en_t10_busy", busy, 0);
    tick(1); chk("en_t11_busy", busy, 0);
    // Reset mid-strobe, then re-accept of the held SET request
    en = 1; sv = 8'h22; #1;
    chk("rs_t0_set_ready", sr, 1);
    tick(4); chk("rs_t4_strobe_pre", stb, 1);
    rstn = 0; #1;
    chk("rs_async_strobe", stb, 0);
    chk("rs_async_data", data, 8'h00);
    chk("rs_async_busy", busy, 0);
    tick(1); rstn = 1; #1;
    chk("rr_t0_set_ready", sr, 1);
    tick(1); chk("rr_t1_data", data, 8'h22); chk("rr_t1_cfg", cfg, 1); sval = 0;
    tick(1); chk("rr_t2_strobe", stb, 0);
    tick(1); chk("rr_t3_strobe", stb, 1);
    tick(3); chk("rr_t6_strobe", stb, 1);
    tick(1); chk("rr_t7_strobe", stb, 0);
    tick(1); chk("rr_t8_busy", busy, 1);
    tick(1); chk("rr_t9_done", done, 1);
    // Minimum timing instance: S=W=H=1
    f_rstn = 1; f_en = 1; f_aval = 1; f_av = 8'hFF; #1;
    chk("f_t0_adc_ready", f_ar, 1);
    tick(1); chk("f_t1_strobe", f_stb, 0); chk("f_t1_data", f_data, 8'hFF); chk("f_t1_busy", f_busy, 1);
    tick(1); chk("f_t2_strobe", f_stb, 1);
    tick(1); chk("f_t3_strobe", f_stb, 0); chk("f_t3_done", f_done, 0);
    tick(1); chk("f_t4_done", f_done, 1); chk("f_t4_adc_ready", f_ar, 1); chk("f_t4_busy", f_busy, 0);
    tick(1); chk("f_t5_busy", f_busy, 1); chk("f_t5_strobe", f_stb, 0);
    f_aval = 0;
    tick(4);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
